axi_rid_order_tracker: RTL and testbench

Read-ID order tracker on the AXI read path of the DDR/frame-buffer interface. It pushes every accepted AR ID into the downstream prefetch RID FIFO and throttles AR when the FIFO or the outstanding limit is full. It gates R beats until the expected ID is presented at the FIFO head, checks each beat's RID against that head, and pops the FIFO on RLAST. Errors are sticky and captured for the status register block.

---
 rtl/axi_rid_order_tracker_pkg.sv | 11 +
 rtl/axi_rid_order_tracker_if.sv | 36 +++
 rtl/axi_rid_order_tracker.sv | 126 ++++++++++++
 tb/tb_axi_rid_order_tracker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rid_order_tracker_pkg.sv
// Shared definitions for the AXI read-ID order tracker: default widths/limits and the R-side FSM states.
package axi_rid_pkg;
  localparam int ID_WIDTH        = 4;
  localparam int MAX_OUTSTANDING = 16;
  localparam int CNT_WIDTH       = 11;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;
endpackage

// File: rtl/axi_rid_order_tracker_if.sv
// AR/R handshake and RID FIFO signals; the tracker uses the slave modport, its environment the master one.
interface axi_rid_order_tracker_if #(
  parameter int ID_WIDTH = 4
);
  logic                s_arvalid;
  logic                s_arready;
  logic [ID_WIDTH-1:0] s_arid;
  logic                m_arvalid;
  logic                m_arready;
  logic                s_rvalid;
  logic                s_rready;
  logic [ID_WIDTH-1:0] s_rid;
  logic                s_rlast;
  logic                m_rvalid;
  logic                m_rready;
  logic                fifo_wr_en;
  logic                fifo_wr_vld;
  logic [ID_WIDTH-1:0] fifo_wr_data;
  logic                fifo_rd_en;
  logic                fifo_rd_vld;
  logic [ID_WIDTH-1:0] fifo_rd_data;

  // valid/ready: a transfer happens on a clock edge where both are high; ready may depend
  // combinationally on valid's partner-side gating, and no payload is held without valid.
  modport slave (
    input  s_arvalid, s_arid, m_arready, s_rvalid, s_rid, s_rlast, m_rready,
           fifo_wr_vld, fifo_rd_vld, fifo_rd_data,
    output s_arready, m_arvalid, s_rready, m_rvalid, fifo_wr_en, fifo_wr_data, fifo_rd_en
  );

  modport master (
    output s_arvalid, s_arid, m_arready, s_rvalid, s_rid, s_rlast, m_rready,
           fifo_wr_vld, fifo_rd_vld, fifo_rd_data,
    input  s_arready, m_arvalid, s_rready, m_rvalid, fifo_wr_en, fifo_wr_data, fifo_rd_en
  );
endinterface

// File: rtl/axi_rid_order_tracker.sv
// Read-ID order tracker: pushes AR IDs into the RID FIFO, throttles AR on limit/full,
// gates R beats on the FIFO head, checks RIDs and keeps sticky error/status state.
module axi_rid_order_tracker #(
  parameter int ID_WIDTH        = axi_rid_pkg::ID_WIDTH,
  parameter int MAX_OUTSTANDING = axi_rid_pkg::MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = axi_rid_pkg::CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_rid_order_tracker_if.slave bus,
  input  logic                   err_clr,
  output logic                   err_mismatch,
  output logic                   err_unexpected,
  output logic [ID_WIDTH-1:0]    err_exp_id,
  output logic [ID_WIDTH-1:0]    err_got_id,
  output logic [CNT_WIDTH-1:0]   outstanding,
  output logic [31:0]            burst_done_cnt,
  output axi_rid_pkg::r_state_e  o_dbg_state
);
  import axi_rid_pkg::*;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic                w_ar_ok;
  logic                w_ar_hs;
  logic                w_r_ok;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_mismatch;
  logic                w_unexpected;
  logic [ID_WIDTH-1:0] w_exp_id;
  r_state_e            w_state_next;

  r_state_e            r_state;
  logic [ID_WIDTH-1:0] r_exp_id;
  logic [CNT_WIDTH-1:0] r_outstanding;
  logic [31:0]         r_done_cnt;
  logic                r_err_mismatch;
  logic                r_err_unexpected;
  logic [ID_WIDTH-1:0] r_err_exp_id;
  logic [ID_WIDTH-1:0] r_err_got_id;

  // The limit compare uses the registered count, so a freed slot is usable one cycle later.
  assign w_ar_ok          = bus.fifo_wr_vld & (r_outstanding < MAX_CNT);
  assign bus.m_arvalid    = bus.s_arvalid & w_ar_ok;
  assign bus.s_arready    = bus.m_arready & w_ar_ok;
  assign w_ar_hs          = bus.s_arvalid & bus.m_arready & w_ar_ok;
  assign bus.fifo_wr_en   = w_ar_hs;
  assign bus.fifo_wr_data = bus.s_arid;

  assign w_r_ok         = bus.fifo_rd_vld;
  assign bus.m_rvalid   = bus.s_rvalid & w_r_ok;
  assign bus.s_rready   = bus.m_rready & w_r_ok;
  assign w_beat         = bus.s_rvalid & bus.m_rready & w_r_ok;
  assign w_last_beat    = w_beat & bus.s_rlast;
  assign bus.fifo_rd_en = w_last_beat;

  assign w_exp_id     = (r_state == R_BURST) ? r_exp_id : bus.fifo_rd_data;
  assign w_mismatch   = w_beat & (bus.s_rid != w_exp_id);
  assign w_unexpected = bus.s_rvalid & (r_outstanding == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      R_IDLE:  if (w_beat && !bus.s_rlast) w_state_next = R_BURST;
      R_BURST: if (w_last_beat) w_state_next = R_IDLE;
      default: w_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      r_exp_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == R_IDLE && w_beat && !bus.s_rlast) r_exp_id <= bus.fifo_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_done_cnt    <= '0;
    end else begin
      case ({w_ar_hs, w_last_beat})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_last_beat) r_done_cnt <= r_done_cnt + 32'd1;
    end
  end

  // A new error beats a simultaneous clear; a mismatch coinciding with a clear is the new first one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_mismatch   <= 1'b0;
      r_err_unexpected <= 1'b0;
      r_err_exp_id     <= '0;
      r_err_got_id     <= '0;
    end else begin
      if (w_mismatch) begin
        r_err_mismatch <= 1'b1;
        if (!r_err_mismatch || err_clr) begin
          r_err_exp_id <= w_exp_id;
          r_err_got_id <= bus.s_rid;
        end
      end else if (err_clr) begin
        r_err_mismatch <= 1'b0;
        r_err_exp_id   <= '0;
        r_err_got_id   <= '0;
      end
      if (w_unexpected)  r_err_unexpected <= 1'b1;
      else if (err_clr)  r_err_unexpected <= 1'b0;
    end
  end

  assign err_mismatch   = r_err_mismatch;
  assign err_unexpected = r_err_unexpected;
  assign err_exp_id     = r_err_exp_id;
  assign err_got_id     = r_err_got_id;
  assign outstanding    = r_outstanding;
  assign burst_done_cnt = r_done_cnt;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_axi_rid_order_tracker.sv
// Bench for axi_rid_order_tracker with a behavioural prefetch RID FIFO and an AR-ID scoreboard.
module tb_axi_rid_order_tracker;
  localparam int IDW   = 4;
  localparam int MAXO  = 4;
  localparam int CNTW  = 11;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  err_clr = 1'b0;
  logic                  err_mismatch, err_unexpected;
  logic [IDW-1:0]        err_exp_id, err_got_id;
  logic [CNTW-1:0]       outstanding;
  logic [31:0]           burst_done_cnt;
  axi_rid_pkg::r_state_e dbg_state;

  axi_rid_order_tracker_if #(.ID_WIDTH(IDW)) bus ();

  axi_rid_order_tracker #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr),
    .err_mismatch(err_mismatch), .err_unexpected(err_unexpected),
    .err_exp_id(err_exp_id), .err_got_id(err_got_id),
    .outstanding(outstanding), .burst_done_cnt(burst_done_cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RID FIFO model (head visible the cycle after a push) ----------------
  logic [IDW-1:0] fifo_q[$];
  logic           fifo_full = 1'b0;
  logic           force_full = 1'b0;
  assign bus.fifo_wr_vld = !fifo_full && !force_full;

  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      bus.fifo_rd_vld  <= 1'b0;
      bus.fifo_rd_data <= '0;
      fifo_full        <= 1'b0;
    end else begin
      if (bus.fifo_wr_en) fifo_q.push_back(bus.fifo_wr_data);
      if (bus.fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.fifo_rd_vld  <= (fifo_q.size() > 0);
      bus.fifo_rd_data <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
      fifo_full        <= (fifo_q.size() >= DEPTH);
    end
  end

  // ---------------- scoreboard ----------------
  int             n_checks = 0;
  int             n_errors = 0;
  int             beat_cnt = 0;
  int             pop_cnt = 0;
  int             exp_done = 0;
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] sb_id;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_wr_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_push: got unexpected push id=%0d, required no push", bus.fifo_wr_data);
        end else begin
          sb_id = exp_q.pop_front();
          if (bus.fifo_wr_data !== sb_id) begin
            n_errors++;
            $display("FAIL sb_push_id: got %0d required %0d", bus.fifo_wr_data, sb_id);
          end
        end
      end
      if (bus.m_rvalid && bus.m_rready) beat_cnt++;
      if (bus.fifo_rd_en) pop_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ar(input logic [IDW-1:0] id, input bit push, output int waits);
    bus.s_arvalid = 1'b1;
    bus.s_arid    = id;
    if (push) exp_q.push_back(id);
    waits = 0;
    @(negedge clk);
    while (!bus.s_arready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.s_arready) begin
      n_checks++; n_errors++;
      $display("FAIL ar_timeout: id=%0d s_arready=%0b required 1", id, bus.s_arready);
    end
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
  endtask

  task automatic wait_rready(input string tag);
    int w = 0;
    @(negedge clk);
    while (!bus.s_rready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!bus.s_rready) begin
      n_checks++; n_errors++;
      $display("FAIL %s: s_rready=%0b required 1 within 100 cycles", tag, bus.s_rready);
    end
  endtask

  task automatic drive_r_burst(input logic [IDW-1:0] id, input int len);
    for (int b = 0; b < len; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rid    = id;
      bus.s_rlast  = (b == len - 1);
      wait_rready("r_timeout");
      @(posedge clk); #1;
    end
    exp_done++;
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (outstanding !== '0) begin n_errors++; $display("FAIL rst_outstanding: got %0d required 0", outstanding); end
    n_checks++; if (burst_done_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_done: got %0d required 0", burst_done_cnt); end
    n_checks++; if ({err_mismatch, err_unexpected} !== 2'b00) begin n_errors++; $display("FAIL rst_errs: got %b required 00", {err_mismatch, err_unexpected}); end
    n_checks++; if ({err_exp_id, err_got_id} !== '0) begin n_errors++; $display("FAIL rst_capture: got %h required 0", {err_exp_id, err_got_id}); end
    n_checks++; if (dbg_state !== axi_rid_pkg::R_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d required R_IDLE", dbg_state); end
    n_checks++; if ({bus.m_arvalid, bus.s_arready, bus.m_rvalid, bus.s_rready, bus.fifo_wr_en, bus.fifo_rd_en} !== 6'b0) begin
      n_errors++; $display("FAIL rst_comb: got %b required 000000", {bus.m_arvalid, bus.s_arready, bus.m_rvalid, bus.s_rready, bus.fifo_wr_en, bus.fifo_rd_en});
    end
    rst_n = 1'b1;
    bus.m_arready = 1'b1;
    bus.m_rready  = 1'b1;
  endtask

  task automatic test_single();
    int w, b0, p0;
    b0 = beat_cnt; p0 = pop_cnt;
    drive_ar(4'd3, 1'b1, w);
    n_checks++; if (outstanding !== 11'd1) begin n_errors++; $display("FAIL single_out1: got %0d required 1", outstanding); end
    drive_r_burst(4'd3, 4);
    n_checks++; if (outstanding !== 11'd0) begin n_errors++; $display("FAIL single_out0: got %0d required 0", outstanding); end
    n_checks++; if (burst_done_cnt !== 32'd1) begin n_errors++; $display("FAIL single_done: got %0d required 1", burst_done_cnt); end
    n_checks++; if (beat_cnt - b0 != 4 || pop_cnt - p0 != 1) begin n_errors++; $display("FAIL single_beats: got beats=%0d pops=%0d required 4/1", beat_cnt - b0, pop_cnt - p0); end
    n_checks++; if ({err_mismatch, err_unexpected} !== 2'b00) begin n_errors++; $display("FAIL single_errs: got %b required 00", {err_mismatch, err_unexpected}); end
  endtask

  task automatic test_ordering();
    int w, b0, p0;
    b0 = beat_cnt; p0 = pop_cnt;
    drive_ar(4'd1, 1'b1, w);
    drive_ar(4'd2, 1'b1, w);
    drive_ar(4'd5, 1'b1, w);
    n_checks++; if (outstanding !== 11'd3) begin n_errors++; $display("FAIL order_out3: got %0d required 3", outstanding); end
    drive_r_burst(4'd1, 1);
    drive_r_burst(4'd2, 2);
    drive_r_burst(4'd5, 3);
    n_checks++; if (beat_cnt - b0 != 6 || pop_cnt - p0 != 3) begin n_errors++; $display("FAIL order_beats: got beats=%0d pops=%0d required 6/3", beat_cnt - b0, pop_cnt - p0); end
    n_checks++; if (burst_done_cnt !== 32'(exp_done)) begin n_errors++; $display("FAIL order_done: got %0d required %0d", burst_done_cnt, exp_done); end
    n_checks++; if ({err_mismatch, err_unexpected, outstanding} !== '0) begin n_errors++; $display("FAIL order_idle: got err=%b out=%0d required 00/0", {err_mismatch, err_unexpected}, outstanding); end
  endtask

  task automatic test_mismatch();
    int w;
    drive_ar(4'd7, 1'b1, w);
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd6; bus.s_rlast = 1'b0;
    wait_rready("mm_timeout");
    @(posedge clk); #1;
    n_checks++; if (dbg_state !== axi_rid_pkg::R_BURST) begin n_errors++; $display("FAIL mm_state: got %0d required R_BURST", dbg_state); end
    drive_r_burst(4'd6, 1);
    n_checks++; if ({err_mismatch, err_exp_id, err_got_id} !== {1'b1, 4'd7, 4'd6}) begin
      n_errors++; $display("FAIL mm_first: got %b/%0d/%0d required 1/7/6", err_mismatch, err_exp_id, err_got_id);
    end
    drive_ar(4'd9, 1'b1, w);
    drive_r_burst(4'd4, 1);
    n_checks++; if ({err_mismatch, err_exp_id, err_got_id} !== {1'b1, 4'd7, 4'd6}) begin
      n_errors++; $display("FAIL mm_sticky: got %b/%0d/%0d required 1/7/6", err_mismatch, err_exp_id, err_got_id);
    end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_checks++; if ({err_mismatch, err_exp_id, err_got_id} !== '0) begin n_errors++; $display("FAIL mm_clear: got %b/%0d/%0d required 0/0/0", err_mismatch, err_exp_id, err_got_id); end
    // first beat matches the head, rlast beat differs from the latched ID
    drive_ar(4'd2, 1'b1, w);
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd2; bus.s_rlast = 1'b0;
    wait_rready("mm2_timeout");
    @(posedge clk); #1;
    drive_r_burst(4'd3, 1);
    n_checks++; if ({err_mismatch, err_exp_id, err_got_id} !== {1'b1, 4'd2, 4'd3}) begin
      n_errors++; $display("FAIL mm_burst: got %b/%0d/%0d required 1/2/3", err_mismatch, err_exp_id, err_got_id);
    end
    drive_ar(4'd5, 1'b1, w);
    err_clr = 1'b1;
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd0; bus.s_rlast = 1'b1;
    wait_rready("mm3_timeout");
    @(posedge clk); #1;
    err_clr = 1'b0; bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; exp_done++;
    n_checks++; if ({err_mismatch, err_exp_id, err_got_id} !== {1'b1, 4'd5, 4'd0}) begin
      n_errors++; $display("FAIL mm_err_wins: got %b/%0d/%0d required 1/5/0", err_mismatch, err_exp_id, err_got_id);
    end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_checks++; if (burst_done_cnt !== 32'(exp_done)) begin n_errors++; $display("FAIL mm_done: got %0d required %0d", burst_done_cnt, exp_done); end
  endtask

  task automatic test_limit();
    logic [IDW-1:0] ids[6];
    int w;
    for (int i = 0; i < 6; i++) ids[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) drive_ar(ids[i], 1'b1, w);
    n_checks++; if (outstanding !== 11'd4) begin n_errors++; $display("FAIL lim_out4: got %0d required 4", outstanding); end
    bus.s_arvalid = 1'b1; bus.s_arid = ids[4];
    repeat (3) begin
      @(negedge clk);
      n_checks++; if ({bus.s_arready, bus.m_arvalid} !== 2'b00) begin n_errors++; $display("FAIL lim_block: got %b required 00", {bus.s_arready, bus.m_arvalid}); end
    end
    @(posedge clk); #1;
    bus.s_rvalid = 1'b1; bus.s_rid = ids[0]; bus.s_rlast = 1'b1;
    wait_rready("lim_r_timeout");
    n_checks++; if (bus.s_arready !== 1'b0) begin n_errors++; $display("FAIL lim_same_cycle: got s_arready=%b required 0", bus.s_arready); end
    @(posedge clk); #1;
    bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; exp_done++;
    drive_ar(ids[4], 1'b1, w);
    n_checks++; if (w != 0) begin n_errors++; $display("FAIL lim_fifth: got wait=%0d required 0", w); end
    bus.s_arvalid = 1'b1; bus.s_arid = ids[5]; exp_q.push_back(ids[5]);
    @(negedge clk);
    n_checks++; if (bus.s_arready !== 1'b0) begin n_errors++; $display("FAIL lim_sixth_block: got %b required 0", bus.s_arready); end
    @(posedge clk); #1;
    drive_r_burst(ids[1], 1);
    drive_ar(ids[5], 1'b0, w);
    for (int i = 2; i < 6; i++) drive_r_burst(ids[i], 1);
    n_checks++; if (outstanding !== 11'd0) begin n_errors++; $display("FAIL lim_drain: got %0d required 0", outstanding); end
    n_checks++; if (err_mismatch !== 1'b0) begin n_errors++; $display("FAIL lim_err: got %b required 0", err_mismatch); end
  endtask

  task automatic test_back_to_back();
    logic [IDW-1:0] ids[4];
    int lens[4];
    int n, w, b0, p0, sum;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      b0 = beat_cnt; p0 = pop_cnt; sum = 0;
      for (int i = 0; i < n; i++) begin
        ids[i]  = 4'($urandom_range(0, 15));
        lens[i] = $urandom_range(1, 4);
        sum += lens[i];
        drive_ar(ids[i], 1'b1, w);
      end
      for (int i = 0; i < n; i++) drive_r_burst(ids[i], lens[i]);
      n_checks++; if (beat_cnt - b0 != sum || pop_cnt - p0 != n) begin
        n_errors++; $display("FAIL b2b_beats: got beats=%0d pops=%0d required %0d/%0d", beat_cnt - b0, pop_cnt - p0, sum, n);
      end
      n_checks++; if (burst_done_cnt !== 32'(exp_done) || err_mismatch !== 1'b0) begin
        n_errors++; $display("FAIL b2b_done: got %0d err=%b required %0d err=0", burst_done_cnt, err_mismatch, exp_done);
      end
    end
  endtask

  task automatic test_fifo_full();
    force_full = 1'b1;
    bus.s_arvalid = 1'b1; bus.s_arid = 4'd11;
    @(negedge clk);
    n_checks++; if ({bus.m_arvalid, bus.s_arready, bus.fifo_wr_en} !== 3'b000) begin
      n_errors++; $display("FAIL full_block: got %b required 000", {bus.m_arvalid, bus.s_arready, bus.fifo_wr_en});
    end
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    force_full = 1'b0;
    n_checks++; if (outstanding !== 11'd0) begin n_errors++; $display("FAIL full_out: got %0d required 0", outstanding); end
  endtask

  task automatic test_unexpected();
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd3; bus.s_rlast = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.s_rready, bus.m_rvalid} !== 2'b00) begin n_errors++; $display("FAIL unexp_stall: got %b required 00", {bus.s_rready, bus.m_rvalid}); end
    @(posedge clk); #1;
    bus.s_rvalid = 1'b0;
    n_checks++; if (err_unexpected !== 1'b1) begin n_errors++; $display("FAIL unexp_flag: got %b required 1", err_unexpected); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_checks++; if (err_unexpected !== 1'b0) begin n_errors++; $display("FAIL unexp_clear: got %b required 0", err_unexpected); end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    drive_ar(4'd4, 1'b1, w);
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd4; bus.s_rlast = 1'b0;
    wait_rready("rmb_timeout");
    @(posedge clk); #1;
    bus.s_rvalid = 1'b0;
    n_checks++; if (dbg_state !== axi_rid_pkg::R_BURST || outstanding !== 11'd1) begin
      n_errors++; $display("FAIL rmb_pre: got state=%0d out=%0d required R_BURST/1", dbg_state, outstanding);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dbg_state !== axi_rid_pkg::R_IDLE || outstanding !== '0 || burst_done_cnt !== 32'd0) begin
      n_errors++; $display("FAIL rmb_regs: got state=%0d out=%0d done=%0d required R_IDLE/0/0", dbg_state, outstanding, burst_done_cnt);
    end
    n_checks++; if ({err_mismatch, err_unexpected, bus.s_rready, bus.m_rvalid} !== 4'b0) begin
      n_errors++; $display("FAIL rmb_outs: got %b required 0000", {err_mismatch, err_unexpected, bus.s_rready, bus.m_rvalid});
    end
    rst_n = 1'b1;
    exp_done = 0;
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd4;
    @(negedge clk);
    n_checks++; if (bus.s_rready !== 1'b0) begin n_errors++; $display("FAIL rmb_stall: got %b required 0", bus.s_rready); end
    @(posedge clk); #1;
    bus.s_rvalid = 1'b0;
    n_checks++; if (err_unexpected !== 1'b1) begin n_errors++; $display("FAIL rmb_unexp: got %b required 1", err_unexpected); end
  endtask

  initial begin
    bus.s_arvalid = 1'b0; bus.s_arid = '0; bus.m_arready = 1'b0;
    bus.s_rvalid  = 1'b0; bus.s_rid  = '0; bus.s_rlast   = 1'b0; bus.m_rready = 1'b0;
    test_reset();
    test_single();
    test_ordering();
    test_mismatch();
    test_limit();
    test_back_to_back();
    test_fifo_full();
    test_unexpected();
    test_reset_mid_burst();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover: got %0d pending pushes required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
